// File: rtl/scanline_buffer_writer_pkg.sv
// Shared constants for the line-buffer fill path: buffer geometry defaults and
// the fill FSM encoding.
package scanline_buffer_writer_pkg;

  // Half offset must match the output stage, which reads half 1 at 640.
  localparam int DEFAULT_LINE_PIXELS = 640;
  localparam int DEFAULT_HALF_OFFSET = 640;
  localparam int DEFAULT_LINES       = 240;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_EXPAND    = 2'd2,
    ST_WAIT_LINE = 2'd3
  } fill_state_t;

  // Index of the scanline that makes the next fill due (lines per half minus one).
  function automatic logic [1:0] last_line_index(input logic scale);
    return scale ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/scanline_buffer_writer_pixel_expander.sv
// Turns one loaded bitmap byte into an 8-cycle MSB-first pixel stream;
// done marks the cycle carrying the eighth pixel.
module scanline_buffer_writer_pixel_expander (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       pixel_valid,
  output logic       pixel,
  output logic       done
);

  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       active_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= 8'd0;
      bit_cnt_r <= 3'd0;
      active_r  <= 1'b0;
    end else if (abort) begin
      shift_r   <= 8'd0;
      bit_cnt_r <= 3'd0;
      active_r  <= 1'b0;
    end else if (load) begin
      shift_r   <= load_data;
      bit_cnt_r <= 3'd0;
      active_r  <= 1'b1;
    end else if (active_r) begin
      shift_r   <= {shift_r[6:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        active_r <= 1'b0;
      end
    end
  end

  assign pixel_valid = active_r;
  assign pixel       = shift_r[7];
  assign done        = active_r && (bit_cnt_r == 3'd7);

endmodule

// File: rtl/scanline_buffer_writer.sv
// Fills the double-buffered line RAM from 1-bpp VRAM, one buffer half per
// 2 or 4 scanlines, paced by the frame/render/scanline pulses.
module scanline_buffer_writer
  import scanline_buffer_writer_pkg::*;
#(
  parameter int LINE_PIXELS = DEFAULT_LINE_PIXELS,
  parameter int LINES       = DEFAULT_LINES,
  parameter int HALF_OFFSET = DEFAULT_HALF_OFFSET
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        render_start,
  input  logic        scanline_start,
  input  logic        pixel_scale,
  input  logic [15:0] fb_base,
  output logic [15:0] vram_addr,
  output logic        vram_rd_req,
  input  logic        vram_rd_ack,
  input  logic [7:0]  vram_data,
  output logic        lb_wr_en,
  output logic [10:0] lb_wr_addr,
  output logic [7:0]  lb_wr_data,
  output logic        busy,
  output logic        underrun
);

  localparam int PIX_W  = $clog2(LINE_PIXELS);
  localparam int FILL_W = $clog2(LINES + 1);

  fill_state_t       state;
  logic              scale_r;
  logic              half_r;
  logic              pending_r;
  logic              frame_active_r;
  logic [1:0]        line_cnt_r;
  logic [PIX_W-1:0]  pix_cnt_r;
  logic [FILL_W-1:0] fill_count_r;

  logic scan_tick;
  logic fill_due;
  logic fill_running;
  logic abort;
  logic load;
  logic last_pixel;
  logic last_fill;
  logic exp_valid;
  logic exp_pixel;
  logic exp_done;

  // render_start wins over a coincident scanline_start: line_cnt restarts at 0.
  assign scan_tick    = scanline_start && frame_active_r && !render_start;
  assign fill_due     = scan_tick && (line_cnt_r == last_line_index(scale_r));
  assign fill_running = (state == ST_FETCH) || (state == ST_EXPAND);
  assign abort        = frame_start || render_start;
  assign load         = (state == ST_FETCH) && vram_rd_ack && !abort;
  assign last_pixel   = (pix_cnt_r == PIX_W'(LINE_PIXELS - 1));
  assign last_fill    = (fill_count_r == FILL_W'(LINES - 1));

  scanline_buffer_writer_pixel_expander u_expander (
    .clk         (sys_clk),
    .rst_n       (reset_n),
    .abort       (abort),
    .load        (load),
    .load_data   (vram_data),
    .pixel_valid (exp_valid),
    .pixel       (exp_pixel),
    .done        (exp_done)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      vram_addr      <= 16'd0;
      vram_rd_req    <= 1'b0;
      scale_r        <= 1'b0;
      half_r         <= 1'b0;
      pending_r      <= 1'b0;
      frame_active_r <= 1'b0;
      line_cnt_r     <= 2'd0;
      pix_cnt_r      <= '0;
      fill_count_r   <= '0;
      underrun       <= 1'b0;
    end else begin
      if (scan_tick) begin
        line_cnt_r <= fill_due ? 2'd0 : line_cnt_r + 2'd1;
      end
      if (fill_due && fill_running) begin
        pending_r <= 1'b1;
        underrun  <= 1'b1;
      end

      if (abort) begin
        // frame_start first; a coincident render_start then restarts from fb_base.
        if (frame_start) begin
          vram_addr      <= fb_base;
          underrun       <= 1'b0;
          fill_count_r   <= '0;
          state          <= ST_IDLE;
          vram_rd_req    <= 1'b0;
          pending_r      <= 1'b0;
          frame_active_r <= 1'b0;
        end
        if (render_start) begin
          scale_r        <= pixel_scale;
          line_cnt_r     <= 2'd0;
          half_r         <= 1'b0;
          pix_cnt_r      <= '0;
          fill_count_r   <= '0;
          pending_r      <= 1'b0;
          frame_active_r <= 1'b1;
          state          <= ST_FETCH;
          vram_rd_req    <= 1'b1;
        end
      end else begin
        case (state)
          ST_FETCH: begin
            if (vram_rd_ack) begin
              vram_rd_req <= 1'b0;
              vram_addr   <= vram_addr + 16'd1;
              state       <= ST_EXPAND;
            end
          end
          ST_EXPAND: begin
            if (exp_valid) begin
              if (exp_done && last_pixel) begin
                pix_cnt_r    <= '0;
                half_r       <= ~half_r;
                fill_count_r <= fill_count_r + FILL_W'(1);
                if (last_fill) begin
                  state          <= ST_IDLE;
                  frame_active_r <= 1'b0;
                  pending_r      <= 1'b0;
                end else if (pending_r || fill_due) begin
                  state       <= ST_FETCH;
                  vram_rd_req <= 1'b1;
                  pending_r   <= 1'b0;
                end else begin
                  state <= ST_WAIT_LINE;
                end
              end else begin
                pix_cnt_r <= pix_cnt_r + PIX_W'(1);
                if (exp_done) begin
                  state       <= ST_FETCH;
                  vram_rd_req <= 1'b1;
                end
              end
            end
          end
          ST_WAIT_LINE: begin
            if (fill_due) begin
              state       <= ST_FETCH;
              vram_rd_req <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign lb_wr_en   = exp_valid;
  assign lb_wr_data = {7'b0, exp_pixel};
  assign lb_wr_addr = (half_r ? 11'(HALF_OFFSET) : 11'd0) + 11'(pix_cnt_r);
  assign busy       = fill_running || pending_r;

endmodule
